// File: rtl/branch_resolver.sv
// EX-stage branch resolver: in-order prediction FIFO, BTB update/redirect generation and wrong-path flush FSM.
// Optional statistics counters are built only when BRANCH_RESOLVER_STATS_EN is defined.
module branch_resolver #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic        pred_valid,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  output logic        fetch_ready,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_branch,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        update,
  output logic [31:0] updatePC,
  output logic [31:0] updateTarget,
  output logic        mispredicted,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        sync_err,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [AW:0]   L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0]   L_CNT1  = (AW+1)'(1);
  localparam logic [AW-1:0] L_PTR1  = AW'(1);
  localparam logic [CW-1:0] L_FLUSH = CW'(FLUSH_CYCLES);
  localparam logic [CW-1:0] L_FC1   = CW'(1);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [CW-1:0] r_fcnt, w_fcnt_nxt;

  logic [31:0] r_pc_q  [DEPTH];
  logic        r_eff_q [DEPTH];
  logic [31:0] r_tgt_q [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [AW:0]   r_count;

  logic        r_update, r_mispredicted, r_redirect, r_sync_err;
  logic [31:0] r_update_pc, r_update_tgt, r_redirect_pc;

  logic        w_run, w_head_hit, w_resolve, w_order_err, w_mispred, w_m, w_update, w_push;
  logic [31:0] w_head_pc, w_head_tgt;
  logic        w_head_eff;

  assign w_run       = (r_state == ST_RUN);
  assign w_head_pc   = r_pc_q[r_head];
  assign w_head_eff  = r_eff_q[r_head];
  assign w_head_tgt  = r_tgt_q[r_head];
  assign w_head_hit  = (r_count != '0) && (w_head_pc == ex_pc);
  assign w_resolve   = w_run && ex_valid && w_head_hit;
  assign w_order_err = w_run && ex_valid && !w_head_hit;
  assign w_mispred   = ex_is_branch ? ((w_head_eff != ex_taken) || (ex_taken && (w_head_tgt != ex_target)))
                                    : w_head_eff;
  assign w_m         = w_resolve && w_mispred;
  assign w_update    = w_resolve && ex_is_branch && (ex_taken || w_mispred);
  assign fetch_ready = w_run && ((r_count < L_DEPTH) || w_resolve);
  // a push in the same cycle as a mispredict belongs to the wrong path
  assign w_push      = fetch_valid && fetch_ready && !w_m;

  // Next-state and flush-slot counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      ST_RUN: begin
        if (w_m) begin
          w_state_nxt = ST_FLUSH;
          w_fcnt_nxt  = L_FLUSH;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (ex_valid) begin
          w_fcnt_nxt = r_fcnt - L_FC1;
          if (r_fcnt == L_FC1) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_FLUSH;
          end
        end else begin
          w_state_nxt = ST_FLUSH;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_fcnt_nxt  = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  // Prediction storage (no reset needed: occupancy is tracked by r_count)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_q[r_tail]  <= fetch_pc;
      r_eff_q[r_tail] <= pred_valid & pred_taken;
      r_tgt_q[r_tail] <= pred_target;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_m) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)    r_tail <= r_tail + L_PTR1;
      if (w_resolve) r_head <= r_head + L_PTR1;
      case ({w_push, w_resolve})
        2'b10:   r_count <= r_count + L_CNT1;
        2'b01:   r_count <= r_count - L_CNT1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered BTB update, redirect and sticky ordering error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_update       <= 1'b0;
      r_mispredicted <= 1'b0;
      r_redirect     <= 1'b0;
      r_sync_err     <= 1'b0;
      r_update_pc    <= 32'd0;
      r_update_tgt   <= 32'd0;
      r_redirect_pc  <= 32'd0;
    end else begin
      r_update       <= w_update;
      r_mispredicted <= w_m;
      r_redirect     <= w_m;
      r_sync_err     <= r_sync_err | w_order_err;
      if (w_update) begin
        r_update_pc  <= ex_pc;
        r_update_tgt <= ex_target;
      end
      if (w_m) begin
        r_redirect_pc <= (ex_taken && ex_is_branch) ? ex_target : (ex_pc + 32'd4);
      end
    end
  end

  assign update       = r_update;
  assign updatePC     = r_update_pc;
  assign updateTarget = r_update_tgt;
  assign mispredicted = r_mispredicted;
  assign redirect     = r_redirect;
  assign redirect_pc  = r_redirect_pc;
  assign sync_err     = r_sync_err;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] r_stat_br, r_stat_mp;

  // Saturating statistics counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_br <= 32'd0;
      r_stat_mp <= 32'd0;
    end else begin
      if (w_resolve && ex_is_branch && (r_stat_br != 32'hFFFF_FFFF)) r_stat_br <= r_stat_br + 32'd1;
      if (w_m && (r_stat_mp != 32'hFFFF_FFFF)) r_stat_mp <= r_stat_mp + 32'd1;
    end
  end

  assign stat_branches    = r_stat_br;
  assign stat_mispredicts = r_stat_mp;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: queue-based reference model, directed test-plan cases, random traffic.
module tb_branch_resolver;
  localparam int DEPTH = 4;
  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid, pred_valid, pred_taken, fetch_ready;
  logic [31:0] fetch_pc, pred_target;
  logic        ex_valid, ex_is_branch, ex_taken;
  logic [31:0] ex_pc, ex_target;
  logic        update, mispredicted, redirect, sync_err;
  logic [31:0] updatePC, updateTarget, redirect_pc, stat_branches, stat_mispredicts;

  branch_resolver #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .pred_valid(pred_valid),
    .pred_taken(pred_taken), .pred_target(pred_target), .fetch_ready(fetch_ready),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .update(update), .updatePC(updatePC), .updateTarget(updateTarget),
    .mispredicted(mispredicted), .redirect(redirect), .redirect_pc(redirect_pc),
    .sync_err(sync_err), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        eff;
    logic [31:0] tgt;
  } ent_t;

  ent_t q[$];
  bit   m_flush;
  int   m_fleft;
  int   n_checks = 0;
  int   n_errors = 0;

  logic        e_upd, e_mis, e_red, e_sync;
  logic [31:0] e_upc, e_utgt, e_rpc, e_sb, e_sm;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_flush = 1'b0;
    m_fleft = 0;
    e_upd = 1'b0; e_mis = 1'b0; e_red = 1'b0; e_sync = 1'b0;
    e_upc = 32'd0; e_utgt = 32'd0; e_rpc = 32'd0; e_sb = 32'd0; e_sm = 32'd0;
  endtask

  task automatic do_reset();
    fetch_valid = 1'b0; fetch_pc = 32'd0; pred_valid = 1'b0; pred_taken = 1'b0; pred_target = 32'd0;
    ex_valid = 1'b0; ex_pc = 32'd0; ex_is_branch = 1'b0; ex_taken = 1'b0; ex_target = 32'd0;
    rst = 1'b0;
    #1;
    model_reset();
    chk1("rst_update", update, 1'b0);
    chk1("rst_redirect", redirect, 1'b0);
    chk1("rst_mispredicted", mispredicted, 1'b0);
    chk1("rst_sync_err", sync_err, 1'b0);
    chk32("rst_updatePC", updatePC, 32'd0);
    chk32("rst_redirect_pc", redirect_pc, 32'd0);
    chk32("rst_stat_br", stat_branches, 32'd0);
    chk1("rst_fetch_ready", fetch_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock: drive inputs, predict with the model, then compare registered outputs after the edge.
  task automatic step(input logic fv, input logic [31:0] fpc, input logic pv, input logic pt,
                      input logic [31:0] ptgt, input logic ev, input logic [31:0] epc,
                      input logic br, input logic tk, input logic [31:0] etgt);
    bit   run, hit, res, m, rdy;
    ent_t h;
    ent_t n;
    fetch_valid = fv; fetch_pc = fpc; pred_valid = pv; pred_taken = pt; pred_target = ptgt;
    ex_valid = ev; ex_pc = epc; ex_is_branch = br; ex_taken = tk; ex_target = etgt;
    #1;
    run = !m_flush;
    hit = (q.size() > 0) && (q[0].pc == epc);
    res = run && ev && hit;
    m = 1'b0;
    if (res) begin
      h = q[0];
      m = br ? ((h.eff != tk) || (tk && (h.tgt != etgt))) : h.eff;
    end
    rdy = run && ((q.size() < DEPTH) || res);
    chk1("fetch_ready", fetch_ready, rdy);
    e_upd = res && br && (tk || m);
    if (e_upd) begin
      e_upc  = epc;
      e_utgt = etgt;
    end
    e_mis = m;
    e_red = m;
    if (m) e_rpc = (br && tk) ? etgt : epc + 32'd4;
    if (run && ev && !hit) e_sync = 1'b1;
`ifdef BRANCH_RESOLVER_STATS_EN
    if (res && br) e_sb = e_sb + 32'd1;
    if (m) e_sm = e_sm + 32'd1;
`endif
    if (m_flush) begin
      if (ev) begin
        m_fleft--;
        if (m_fleft == 0) m_flush = 1'b0;
      end
    end else begin
      if (res) void'(q.pop_front());
      if (m) begin
        q.delete();
        m_flush = 1'b1;
        m_fleft = FLUSH_CYCLES;
      end else if (fv && rdy) begin
        n.pc = fpc; n.eff = pv & pt; n.tgt = ptgt;
        q.push_back(n);
      end
    end
    @(posedge clk);
    #1;
    chk1("update", update, e_upd);
    chk1("mispredicted", mispredicted, e_mis);
    chk1("redirect", redirect, e_red);
    chk1("sync_err", sync_err, e_sync);
    if (e_upd) begin
      chk32("updatePC", updatePC, e_upc);
      chk32("updateTarget", updateTarget, e_utgt);
    end
    if (e_red) chk32("redirect_pc", redirect_pc, e_rpc);
    chk32("stat_branches", stat_branches, e_sb);
    chk32("stat_mispredicts", stat_mispredicts, e_sm);
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] pc, input logic pv, input logic pt, input logic [31:0] tgt);
    step(1'b1, pc, pv, pt, tgt, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic exr(input logic [31:0] pc, input logic br, input logic tk, input logic [31:0] tgt);
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, pc, br, tk, tgt);
  endtask

  task automatic idle_ready(input string name, input logic exp);
    fetch_valid = 1'b0; ex_valid = 1'b0;
    #1;
    chk1(name, fetch_ready, exp);
  endtask

  initial begin
    logic [31:0] rpc;
    do_reset();

    // correct-taken branch
    push(32'h100, 1'b1, 1'b1, 32'h200);
    exr(32'h100, 1'b1, 1'b1, 32'h200);
    chk1("tp_taken_update", update, 1'b1);
    chk32("tp_taken_updatePC", updatePC, 32'h100);
    chk32("tp_taken_updateTarget", updateTarget, 32'h200);
    chk1("tp_taken_mispred", mispredicted, 1'b0);
    chk1("tp_taken_redirect", redirect, 1'b0);

    // cold miss taken, then two ignored EX slots with a dropped push
    push(32'h104, 1'b0, 1'b0, 32'h0);
    exr(32'h104, 1'b1, 1'b1, 32'h300);
    chk1("tp_cold_update", update, 1'b1);
    chk1("tp_cold_mispred", mispredicted, 1'b1);
    chk1("tp_cold_redirect", redirect, 1'b1);
    chk32("tp_cold_redirect_pc", redirect_pc, 32'h300);
    idle_ready("tp_cold_flush_ready", 1'b0);
    step(1'b1, 32'h900, 1'b1, 1'b1, 32'h0, 1'b1, 32'h900, 1'b1, 1'b1, 32'h0);
    exr(32'h123, 1'b0, 1'b0, 32'h0);
    idle_ready("tp_cold_run_ready", 1'b1);

    // false hit on a non-branch
    push(32'h108, 1'b1, 1'b1, 32'h50);
    exr(32'h108, 1'b0, 1'b0, 32'h0);
    chk1("tp_false_update", update, 1'b0);
    chk1("tp_false_redirect", redirect, 1'b1);
    chk32("tp_false_redirect_pc", redirect_pc, 32'h10C);
    exr(32'h0, 1'b0, 1'b0, 32'h0);
    exr(32'h0, 1'b0, 1'b0, 32'h0);

    // full FIFO, simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) push(32'h400 + 32'(i) * 32'd4, 1'b0, 1'b0, 32'h0);
    idle_ready("tp_full_ready", 1'b0);
    step(1'b1, 32'h410, 1'b0, 1'b0, 32'h0, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
    idle_ready("tp_full_still", 1'b0);

    // ordering error: head is 0x404
    exr(32'h500, 1'b1, 1'b1, 32'h600);
    chk1("tp_order_sync", sync_err, 1'b1);
    chk1("tp_order_update", update, 1'b0);
    exr(32'h404, 1'b0, 1'b0, 32'h0);
    chk1("tp_order_sticky", sync_err, 1'b1);

    // PC wrap on fall-through redirect, then reset mid-flush
    do_reset();
    push(32'hFFFF_FFFC, 1'b1, 1'b1, 32'h10);
    exr(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    chk32("tp_wrap_redirect_pc", redirect_pc, 32'h0);
    do_reset();

    // statistics: 3 branches, 1 mispredicted
    push(32'h600, 1'b1, 1'b1, 32'h700);
    push(32'h604, 1'b0, 1'b0, 32'h0);
    push(32'h608, 1'b1, 1'b1, 32'h800);
    exr(32'h600, 1'b1, 1'b1, 32'h700);
    exr(32'h604, 1'b1, 1'b0, 32'h0);
    exr(32'h608, 1'b1, 1'b1, 32'h900);
`ifdef BRANCH_RESOLVER_STATS_EN
    chk32("tp_stats_br", stat_branches, 32'd3);
    chk32("tp_stats_mp", stat_mispredicts, 32'd1);
`else
    chk32("tp_stats_br", stat_branches, 32'd0);
    chk32("tp_stats_mp", stat_mispredicts, 32'd0);
`endif

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      if ((q.size() > 0) && ($urandom_range(0, 9) != 0)) rpc = q[0].pc;
      else rpc = 32'h1000 + 32'($urandom_range(0, 15)) * 32'd4;
      step(1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 15)) * 32'd4,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h2000 + 32'($urandom_range(0, 3)) * 32'd4,
           1'($urandom_range(0, 1)), rpc,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 32'h2000 + 32'($urandom_range(0, 3)) * 32'd4);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
